// File: rtl/johnson_phase_decoder_pkg.sv
// Shared constants and helpers for the Johnson-code phase decoder.
package johnson_phase_decoder_pkg;

  localparam int unsigned JC_W       = 4;
  localparam int unsigned NUM_PHASES = 2 * JC_W;
  localparam int unsigned IDX_W      = $clog2(NUM_PHASES);

  function automatic int unsigned next_idx(input int unsigned idx,
                                           input int unsigned num_phases = NUM_PHASES);
    return (idx + 1) % num_phases;
  endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational legality check and index decode of an N-bit Johnson code.
module johnson_code_check
  import johnson_phase_decoder_pkg::*;
#(
  parameter int unsigned N     = JC_W,
  parameter int unsigned IdxW  = $clog2(2 * N)
) (
  input  logic [N-1:0]    jc_in,
  output logic            is_legal,
  output logic [IdxW-1:0] idx
);

  localparam int unsigned NumPh = 2 * N;

  typedef logic [N-1:0]    code_t;
  typedef logic [IdxW-1:0] idx_t;

  logic [NumPh-1:0] match;

  for (genvar k = 0; k < NumPh; k++) begin : g_code
    // Fill with ones from the bottom, then drain them from the bottom.
    localparam code_t Code = (k <= N) ? code_t'((1 << k) - 1)
                                      : code_t'(~((1 << (k - N)) - 1));
    assign match[k] = (jc_in == Code);
  end

  always_comb begin
    is_legal = |match;
    idx      = '0;
    for (int unsigned k = 0; k < NumPh; k++) begin
      if (match[k]) begin
        idx = idx_t'(k);
      end
    end
  end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Registers phase/index from a sampled Johnson code; tracks step errors and revolutions.
module johnson_phase_decoder
  import johnson_phase_decoder_pkg::*;
#(
  parameter int unsigned N     = JC_W,
  parameter int unsigned REV_W = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     en,
  input  logic [N-1:0]             jc_in,
  output logic [2*N-1:0]           phase,
  output logic [$clog2(2*N)-1:0]   phase_idx,
  output logic                     legal,
  output logic                     step_err,
  output logic                     wrap,
  output logic                     err_sticky,
  output logic [REV_W-1:0]         rev_count
);

  localparam int unsigned NumPh = 2 * N;
  localparam int unsigned IdxW  = $clog2(NumPh);

  logic            dec_legal;
  logic [IdxW-1:0] dec_idx;

  johnson_code_check #(
    .N    (N),
    .IdxW (IdxW)
  ) u_check (
    .jc_in    (jc_in),
    .is_legal (dec_legal),
    .idx      (dec_idx)
  );

  logic [NumPh-1:0] phase_q, phase_d;
  logic [IdxW-1:0]  phase_idx_q, phase_idx_d;
  logic             legal_q, legal_d;
  logic             step_err_q, step_err_d;
  logic             wrap_q, wrap_d;
  logic             err_sticky_q, err_sticky_d;
  logic [REV_W-1:0] rev_count_q, rev_count_d;
  logic             prev_valid_q, prev_valid_d;
  logic [IdxW-1:0]  prev_idx_q, prev_idx_d;

  logic is_hold, is_inc, is_wrap;

  always_comb begin
    is_hold = (dec_idx == prev_idx_q);
    is_inc  = (32'(dec_idx) == next_idx(32'(prev_idx_q), NumPh));
    is_wrap = (32'(prev_idx_q) == NumPh - 1) && (dec_idx == '0);
  end

  always_comb begin
    phase_d      = phase_q;
    phase_idx_d  = phase_idx_q;
    legal_d      = legal_q;
    step_err_d   = 1'b0;
    wrap_d       = 1'b0;
    err_sticky_d = err_sticky_q;
    rev_count_d  = rev_count_q;
    prev_valid_d = prev_valid_q;
    prev_idx_d   = prev_idx_q;
    if (en) begin
      if (dec_legal) begin
        phase_d          = '0;
        phase_d[dec_idx] = 1'b1;
        phase_idx_d      = dec_idx;
        legal_d          = 1'b1;
        // Step and wrap checks need a trusted previous index.
        if (prev_valid_q) begin
          if (!is_hold && !is_inc) begin
            step_err_d   = 1'b1;
            err_sticky_d = 1'b1;
          end
          if (is_wrap) begin
            wrap_d      = 1'b1;
            rev_count_d = rev_count_q + 1'b1;
          end
        end
        prev_idx_d   = dec_idx;
        prev_valid_d = 1'b1;
      end else begin
        phase_d      = '0;
        legal_d      = 1'b0;
        err_sticky_d = 1'b1;
        prev_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      phase_q      <= '0;
      phase_idx_q  <= '0;
      legal_q      <= 1'b0;
      step_err_q   <= 1'b0;
      wrap_q       <= 1'b0;
      err_sticky_q <= 1'b0;
      rev_count_q  <= '0;
      prev_valid_q <= 1'b0;
      prev_idx_q   <= '0;
    end else begin
      phase_q      <= phase_d;
      phase_idx_q  <= phase_idx_d;
      legal_q      <= legal_d;
      step_err_q   <= step_err_d;
      wrap_q       <= wrap_d;
      err_sticky_q <= err_sticky_d;
      rev_count_q  <= rev_count_d;
      prev_valid_q <= prev_valid_d;
      prev_idx_q   <= prev_idx_d;
    end
  end

  assign phase      = phase_q;
  assign phase_idx  = phase_idx_q;
  assign legal      = legal_q;
  assign step_err   = step_err_q;
  assign wrap       = wrap_q;
  assign err_sticky = err_sticky_q;
  assign rev_count  = rev_count_q;

endmodule
